corr_seq_ctrl: RTL and testbench

- Sequencer for the correlator's RAM-based 8-bit/256-word delay line and its per-lag accumulator bank.
- Gates ADC sample strobes into the delay-line sync input and enforces the sweep spacing the delay line needs.
- Generates lag index and accumulate-enable aligned to the delay line's shift-data stream.
- Counts samples per integration period, then runs a dump handshake toward the readout logic.

---
 rtl/corr_seq_ctrl_if.sv | 28 ++
 rtl/corr_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_corr_seq_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/corr_seq_ctrl_if.sv
// Control/status bundle between the correlator sequencer and its surroundings.
// master drives start/abort/config/strobes; slave is the sequencer itself.
interface corr_seq_ctrl_if #(
  parameter int unsigned NSAMP_W = 16
) ();
  logic               start;
  logic               abort;
  logic [NSAMP_W-1:0] cfg_nsamp;
  logic               smp_valid;
  logic               sin;
  logic               acc_clr;
  logic               acc_en;
  logic [7:0]         lag_idx;
  logic               dump_req;
  logic               dump_ack;
  logic               busy;
  logic [15:0]        drop_cnt;

  modport master (
    output start, abort, cfg_nsamp, smp_valid, dump_ack,
    input  sin, acc_clr, acc_en, lag_idx, dump_req, busy, drop_cnt
  );

  modport slave (
    input  start, abort, cfg_nsamp, smp_valid, dump_ack,
    output sin, acc_clr, acc_en, lag_idx, dump_req, busy, drop_cnt
  );
endinterface

// File: rtl/corr_seq_ctrl.sv
// Correlator sequencer: gates ADC strobes into delay-line syncs, drives lag/accumulate
// timing and the dump handshake. Define CORR_CONT_EN for continuous (re-arming) mode.
module corr_seq_ctrl #(
  parameter int unsigned NLAG      = 256,
  parameter int unsigned SWEEP_LEN = 258,
  parameter int unsigned LAG_OFS   = 2,
  parameter int unsigned NSAMP_W   = 16
) (
  input logic            clk,
  input logic            rst_n,
  corr_seq_ctrl_if.slave bus
);

  localparam int unsigned TW = $clog2(SWEEP_LEN);

  typedef enum logic [2:0] {StIdle, StClr, StWait, StSweep, StDump} state_e;

  state_e             state_q;
  logic [NSAMP_W-1:0] nsamp_q, cnt_q;
  logic [TW-1:0]      tmr_q;
  logic [15:0]        drop_q;
  logic               sin_q, acc_clr_q, acc_en_q, dump_req_q, busy_q;
  logic [7:0]         lag_q;

  logic [TW-1:0] tmr_dec;
  logic          tmr_zero, last_smp, accept, acc_win;
  logic [7:0]    lag_win;
  int            el;

  assign tmr_dec  = tmr_q - 1'b1;
  assign tmr_zero = (tmr_q == '0);
  assign last_smp = (cnt_q == nsamp_q);
  // The timer==0 clock of a sweep behaves like WAIT for a new strobe.
  assign accept   = bus.smp_valid && !bus.abort &&
                    ((state_q == StWait) || (state_q == StSweep && tmr_zero && !last_smp));

  // Clocks elapsed since the sin clock, as seen in the clock after this one.
  always_comb begin
    el      = int'(SWEEP_LEN) - 1 - int'(tmr_dec);
    acc_win = (el >= int'(LAG_OFS)) && (el < int'(LAG_OFS) + int'(NLAG));
    lag_win = 8'(el - int'(LAG_OFS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      nsamp_q    <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      drop_q     <= '0;
      sin_q      <= 1'b0;
      acc_clr_q  <= 1'b0;
      acc_en_q   <= 1'b0;
      lag_q      <= '0;
      dump_req_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sin_q     <= 1'b0;
      acc_clr_q <= 1'b0;
      acc_en_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            nsamp_q   <= (bus.cfg_nsamp == '0) ? NSAMP_W'(1) : bus.cfg_nsamp;
            cnt_q     <= '0;
            drop_q    <= '0;
            acc_clr_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StClr;
          end
        end
        StClr: begin
          state_q <= bus.abort ? StIdle : StWait;
          busy_q  <= !bus.abort;
        end
        StWait: begin
          if (bus.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StSweep: begin
          if (bus.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (tmr_zero) begin
            if (last_smp) begin
              state_q    <= StDump;
              dump_req_q <= 1'b1;
            end else begin
              state_q <= StWait;
            end
          end else begin
            tmr_q    <= tmr_dec;
            acc_en_q <= acc_win;
            if (acc_win) lag_q <= lag_win;
            if (bus.smp_valid && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
          end
        end
        StDump: begin
`ifdef CORR_CONT_EN
          if (bus.abort) begin
            state_q    <= StIdle;
            dump_req_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (bus.dump_ack) begin
            state_q    <= StClr;
            dump_req_q <= 1'b0;
            acc_clr_q  <= 1'b1;
            cnt_q      <= '0;
          end
`else
          if (bus.dump_ack) begin
            state_q    <= StIdle;
            dump_req_q <= 1'b0;
            busy_q     <= 1'b0;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
      // Accepted strobe overrides the sweep-end WAIT transition above.
      if (accept) begin
        sin_q    <= 1'b1;
        cnt_q    <= cnt_q + 1'b1;
        tmr_q    <= TW'(SWEEP_LEN - 1);
        state_q  <= StSweep;
        acc_en_q <= (LAG_OFS == 0);
        if (LAG_OFS == 0) lag_q <= '0;
      end
    end
  end

  assign bus.sin      = sin_q;
  assign bus.acc_clr  = acc_clr_q;
  assign bus.acc_en   = acc_en_q;
  assign bus.lag_idx  = lag_q;
  assign bus.dump_req = dump_req_q;
  assign bus.busy     = busy_q;
  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_corr_seq_ctrl.sv
// Bench for corr_seq_ctrl: directed scenarios plus random strobes, checked every clock
// against a timestamp-based model of sweep acceptance, lag windows and dump timing.
module tb_corr_seq_ctrl;
  localparam int NONE = 32'h3fffffff;
  localparam int NEG  = -100000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  corr_seq_ctrl_if #(.NSAMP_W(16)) bus ();
  corr_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  // Model: sample acceptance times and the windows they imply.
  bit m_busy;
  int m_nsamp, m_nacc, m_last, m_wait, m_dump, m_drops, m_lag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic reset_model();
    m_busy = 0; m_nacc = 0; m_last = NEG; m_wait = NONE; m_dump = NONE;
    m_drops = 0; m_lag = 0; m_nsamp = 1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sin"}, 32'(bus.sin), 0);
    chk({tag, "_acc_clr"}, 32'(bus.acc_clr), 0);
    chk({tag, "_acc_en"}, 32'(bus.acc_en), 0);
    chk({tag, "_lag"}, 32'(bus.lag_idx), 0);
    chk({tag, "_dump_req"}, 32'(bus.dump_req), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_drop"}, 32'(bus.drop_cnt), 0);
  endtask

  // One clock: drive inputs, advance, update model, compare every output.
  task automatic cyc(input bit st, input bit ab, input bit sv, input bit ak);
    int i, n;
    bit e_sin, e_clr, e_acc, e_dump;
    bus.start = st; bus.abort = ab; bus.smp_valid = sv; bus.dump_ack = ak;
    @(posedge clk); #1;
    i = cyc_n; n = i + 1;
    e_sin = 0; e_clr = 0;
    if (!m_busy) begin
      if (st) begin
        m_busy = 1; m_nsamp = (bus.cfg_nsamp == 0) ? 1 : int'(bus.cfg_nsamp);
        m_nacc = 0; m_drops = 0; m_wait = i + 2; m_dump = NONE; m_last = NEG; e_clr = 1;
      end
    end else if (i >= m_dump) begin
`ifdef CORR_CONT_EN
      if (ab) m_busy = 0;
      else if (ak) begin
        m_nacc = 0; m_wait = i + 2; m_dump = NONE; m_last = NEG; e_clr = 1;
      end
`else
      if (ak) m_busy = 0;
`endif
    end else if (ab) begin
      m_busy = 0;
    end else if (sv) begin
      if (i >= m_wait) begin
        m_last = i; m_nacc++; m_wait = i + 258; e_sin = 1;
        if (m_nacc == m_nsamp) begin m_dump = i + 259; m_wait = NONE; end
      end else if (i >= m_last + 1 && i <= m_last + 257 && m_drops < 65535) begin
        m_drops++;
      end
    end
    e_acc  = m_busy && n >= m_last + 3 && n <= m_last + 258;
    if (e_acc) m_lag = n - m_last - 3;
    e_dump = m_busy && n >= m_dump;
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("sin", 32'(bus.sin), 32'(e_sin));
    chk("acc_clr", 32'(bus.acc_clr), 32'(e_clr));
    chk("acc_en", 32'(bus.acc_en), 32'(e_acc));
    chk("lag_idx", 32'(bus.lag_idx), 32'(m_lag));
    chk("dump_req", 32'(bus.dump_req), 32'(e_dump));
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drops));
    cyc_n++;
    bus.start = 0; bus.abort = 0; bus.smp_valid = 0; bus.dump_ack = 0;
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    int k, dly;
    bus.start = 0; bus.abort = 0; bus.smp_valid = 0; bus.dump_ack = 0; bus.cfg_nsamp = 0;
    rst_n = 0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;
    idle(3);

    // Single-sample integration, ack 5 clocks after dump_req.
    bus.cfg_nsamp = 1;
    cyc(1, 0, 0, 0);
    idle(3);
    cyc(0, 0, 1, 0);
    idle(102);
    chk("lag100_t1", 32'(bus.lag_idx), 100);
    idle(155);
    chk("pre_dump_req", 32'(bus.dump_req), 0);
    idle(1);
    chk("dump_req_t1", 32'(bus.dump_req), 1);
    idle(4);
    cyc(0, 0, 0, 1);
    chk("busy_after_ack", 32'(bus.busy), 0);
    idle(3);

    // Strobes every 100 clocks with nsamp=3.
    bus.cfg_nsamp = 3;
    cyc(1, 0, 0, 0);
    idle(1);
    for (int j = 0; j < 1000; j++) cyc(0, 0, (j % 100) == 0, 0);
    chk("drop_total_t2", 32'(bus.drop_cnt), 6);
    chk("dump_req_t2", 32'(bus.dump_req), 1);
    cyc(0, 0, 0, 1);
    idle(2);

    // Strobe landing exactly on the timer==0 clock.
    bus.cfg_nsamp = 2;
    cyc(1, 0, 0, 0);
    idle(1);
    cyc(0, 0, 1, 0);
    idle(257);
    cyc(0, 0, 1, 0);
    chk("boundary_sin", 32'(bus.sin), 1);
    chk("boundary_drop", 32'(bus.drop_cnt), 0);
    idle(260);
    cyc(0, 0, 0, 1);
    idle(2);

    // Abort at lag 100, then restart.
    bus.cfg_nsamp = 1;
    cyc(1, 0, 0, 0);
    idle(1);
    cyc(0, 0, 1, 0);
    idle(102);
    chk("lag_at_abort", 32'(bus.lag_idx), 100);
    cyc(0, 1, 0, 0);
    chk("acc_en_after_abort", 32'(bus.acc_en), 0);
    idle(300);
    cyc(1, 0, 0, 0);
    chk("restart_clr", 32'(bus.acc_clr), 1);
    idle(1);
    cyc(0, 1, 0, 0);

    // nsamp=0 acts as 1; start+abort together in IDLE: start wins.
    bus.cfg_nsamp = 0;
    cyc(1, 1, 0, 0);
    idle(2);
    cyc(0, 0, 1, 0);
    idle(260);
    cyc(0, 0, 0, 1);
    idle(2);

    // Asynchronous reset in the middle of a sweep.
    bus.cfg_nsamp = 2;
    cyc(1, 0, 0, 0);
    idle(1);
    cyc(0, 0, 1, 0);
    idle(50);
    #2 rst_n = 0;
    #1;
    chk_zero("midsweep_reset");
    @(posedge clk); #1;
    rst_n = 1;
    cyc_n++;
    reset_model();
    idle(2);

`ifdef CORR_CONT_EN
    // Continuous mode: ack re-arms, abort during DUMP returns to IDLE.
    bus.cfg_nsamp = 2;
    cyc(1, 0, 0, 0);
    idle(1);
    for (int r = 0; r < 2; r++) begin
      cyc(0, 0, 1, 0);
      idle(299);
      cyc(0, 0, 1, 0);
      idle(261);
      chk("cont_dump_req", 32'(bus.dump_req), 1);
      cyc(0, 0, 0, 1);
      chk("cont_rearm_clr", 32'(bus.acc_clr), 1);
      chk("cont_busy", 32'(bus.busy), 1);
      idle(1);
    end
    cyc(0, 0, 1, 0);
    idle(258);
    cyc(0, 0, 1, 0);
    idle(260);
    cyc(0, 1, 0, 0);
    chk("cont_abort_dump", 32'(bus.dump_req), 0);
    idle(2);
`endif

    // Random integrations.
    for (int r = 0; r < 6; r++) begin
      bus.cfg_nsamp = 16'($urandom_range(0, 3));
      dly = $urandom_range(0, 6);
      cyc(1, 0, 0, 0);
      k = 0;
      while (m_busy && k < 2500) begin
        cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1999) == 0,
            $urandom_range(0, 99) < 4, m_dump != NONE && cyc_n >= m_dump + dly);
        k++;
      end
      for (int j = 0; j < 3 && m_busy; j++) cyc(0, 1, 0, 1);
      idle(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
